// File: rtl/eg_slot_sched_pkg.sv
// Shared constants, encodings and helpers for the envelope slot scheduler.
package eg_slot_sched_pkg;

   localparam int NUM_SLOTS = 24;   // operator slots per frame
   localparam int NUM_CH    = 6;    // channels; channel = slot % NUM_CH

   // write field selects (3 is reserved and rejected)
   localparam logic [1:0] SEL_TL  = 2'd0;
   localparam logic [1:0] SEL_AMS = 2'd1;
   localparam logic [1:0] SEL_SSG = 2'd2;

   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

   // slot -> channel by subtract-compare; valid for slots 0..23
   function automatic logic [2:0] slot_to_ch(input logic [4:0] s);
      logic [2:0] ch;
      if (s >= 5'd18)      ch = 3'(s - 5'd18);
      else if (s >= 5'd12) ch = 3'(s - 5'd12);
      else if (s >= 5'd6)  ch = 3'(s - 5'd6);
      else                 ch = 3'(s);
      return ch;
   endfunction

endpackage

// File: rtl/eg_slot_sched_if.sv
// CPU register-write bus into the slot scheduler.
interface eg_slot_sched_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_addr;
   logic [1:0] wr_sel;
   logic [6:0] wr_data;
   logic       wr_err;

   modport master (output wr_valid, wr_addr, wr_sel, wr_data,
                   input  wr_ready, wr_err);
   modport slave  (input  wr_valid, wr_addr, wr_sel, wr_data,
                   output wr_ready, wr_err);
endinterface

// File: rtl/eg_slot_sched_regs.sv
// Per-slot operand storage (tl/amsen/ssg_inv) plus per-channel ams.
// One write port, one combinational read port, one clear port.
module eg_slot_regs
   import eg_slot_sched_pkg::*;
(
   input  logic       clk,
   input  logic       clr_en,
   input  logic [4:0] clr_idx,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [1:0] wsel,
   input  logic [6:0] wdata,
   input  logic [4:0] raddr,
   output logic [6:0] rd_tl,
   output logic       rd_amsen,
   output logic [1:0] rd_ams,
   output logic       rd_ssg
);

   logic [6:0] tl_q    [NUM_SLOTS];
   logic [6:0] tl_d    [NUM_SLOTS];
   logic       amsen_q [NUM_SLOTS];
   logic       amsen_d [NUM_SLOTS];
   logic       ssg_q   [NUM_SLOTS];
   logic       ssg_d   [NUM_SLOTS];
   logic [1:0] ams_q   [NUM_CH];
   logic [1:0] ams_d   [NUM_CH];

   // next-state of storage: clear has priority, else apply the field write
   always_comb begin
      tl_d    = tl_q;
      amsen_d = amsen_q;
      ssg_d   = ssg_q;
      ams_d   = ams_q;
      if (clr_en) begin
         tl_d[clr_idx]             = '0;
         amsen_d[clr_idx]          = 1'b0;
         ssg_d[clr_idx]            = 1'b0;
         ams_d[slot_to_ch(clr_idx)] = '0;
      end else if (we) begin
         case (wsel)
            SEL_TL:  tl_d[waddr] = wdata;
            SEL_AMS: begin
               amsen_d[waddr]           = wdata[2];
               ams_d[slot_to_ch(waddr)] = wdata[1:0];
            end
            SEL_SSG: ssg_d[waddr] = wdata[0];
            default: ;
         endcase
      end
   end

   // storage flops; contents are defined by the INIT sweep, not by reset
   always_ff @(posedge clk) begin
      tl_q    <= tl_d;
      amsen_q <= amsen_d;
      ssg_q   <= ssg_d;
      ams_q   <= ams_d;
   end

   // read of the pre-edge value gives read-before-write on collisions
   assign rd_tl    = tl_q[raddr];
   assign rd_amsen = amsen_q[raddr];
   assign rd_ssg   = ssg_q[raddr];
   assign rd_ams   = ams_q[slot_to_ch(raddr)];

endmodule

// File: rtl/eg_slot_sched.sv
// Slot scheduler: INIT sweep, round-robin slot counter, frame-latched LFO,
// registered operand outputs and the register-write handshake.
module eg_slot_sched
   import eg_slot_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   eg_slot_sched_if.slave   wr,
   input  logic [6:0]       lfo_mod_in,
   output logic [4:0]       slot_out,
   output logic             frame_start,
   output logic             op_valid,
   output logic [6:0]       tl,
   output logic             amsen,
   output logic [1:0]       ams,
   output logic             ssg_inv,
   output logic [6:0]       lfo_mod
);

   localparam logic [4:0] LAST = 5'(NUM_SLOTS - 1);

   state_e     state_q, state_d;
   logic [4:0] init_idx_q, init_idx_d;
   logic [4:0] cnt_q, cnt_d;
   logic       wr_ready_q, wr_ready_d;
   logic       wr_err_q, wr_err_d;
   logic [4:0] slot_q, slot_d;
   logic       fs_q, fs_d;
   logic       ov_q, ov_d;
   logic [6:0] tl_q, tl_d;
   logic       amsen_q, amsen_d;
   logic [1:0] ams_q, ams_d;
   logic       ssg_q, ssg_d;
   logic [6:0] lfo_q, lfo_d;

   logic       wr_acc, wr_ok, we;
   logic [6:0] rd_tl;
   logic       rd_amsen, rd_ssg;
   logic [1:0] rd_ams;

   // ready is only ever high in RUN, so an accept implies RUN
   assign wr_acc = wr.wr_valid & wr_ready_q;
   assign wr_ok  = (wr.wr_addr < 5'(NUM_SLOTS)) && (wr.wr_sel != 2'd3);
   assign we     = wr_acc & wr_ok & ~rst;

   eg_slot_regs u_regs (
      .clk      (clk),
      .clr_en   (state_q == ST_INIT),
      .clr_idx  (init_idx_q),
      .we       (we),
      .waddr    (wr.wr_addr),
      .wsel     (wr.wr_sel),
      .wdata    (wr.wr_data),
      .raddr    (cnt_q),
      .rd_tl    (rd_tl),
      .rd_amsen (rd_amsen),
      .rd_ams   (rd_ams),
      .rd_ssg   (rd_ssg)
   );

   // FSM and datapath next-state: INIT sweeps storage, RUN issues slots
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      cnt_d      = cnt_q;
      wr_ready_d = wr_ready_q;
      wr_err_d   = 1'b0;
      slot_d     = slot_q;
      fs_d       = fs_q;
      ov_d       = 1'b0;
      tl_d       = tl_q;
      amsen_d    = amsen_q;
      ams_d      = ams_q;
      ssg_d      = ssg_q;
      lfo_d      = lfo_q;
      case (state_q)
         ST_INIT: begin
            if (init_idx_q == LAST) begin
               state_d    = ST_RUN;
               init_idx_d = '0;
               wr_ready_d = 1'b1;
            end else begin
               init_idx_d = init_idx_q + 5'd1;
            end
         end
         default: begin
            wr_ready_d = 1'b1;
            wr_err_d   = wr_acc & ~wr_ok;
            if (cen) begin
               slot_d  = cnt_q;
               fs_d    = (cnt_q == '0);
               ov_d    = 1'b1;
               tl_d    = rd_tl;
               amsen_d = rd_amsen;
               ams_d   = rd_ams;
               ssg_d   = rd_ssg;
               if (cnt_q == '0) lfo_d = lfo_mod_in;
               cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 5'd1;
            end
         end
      endcase
   end

   // state/output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
         cnt_q      <= '0;
         wr_ready_q <= 1'b0;
         wr_err_q   <= 1'b0;
         slot_q     <= '0;
         fs_q       <= 1'b0;
         ov_q       <= 1'b0;
         tl_q       <= '0;
         amsen_q    <= 1'b0;
         ams_q      <= '0;
         ssg_q      <= 1'b0;
         lfo_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         cnt_q      <= cnt_d;
         wr_ready_q <= wr_ready_d;
         wr_err_q   <= wr_err_d;
         slot_q     <= slot_d;
         fs_q       <= fs_d;
         ov_q       <= ov_d;
         tl_q       <= tl_d;
         amsen_q    <= amsen_d;
         ams_q      <= ams_d;
         ssg_q      <= ssg_d;
         lfo_q      <= lfo_d;
      end
   end

   assign wr.wr_ready = wr_ready_q;
   assign wr.wr_err   = wr_err_q;
   assign slot_out    = slot_q;
   assign frame_start = fs_q;
   assign op_valid    = ov_q;
   assign tl          = tl_q;
   assign amsen       = amsen_q;
   assign ams         = ams_q;
   assign ssg_inv     = ssg_q;
   assign lfo_mod     = lfo_q;

endmodule

// File: tb/tb_eg_slot_sched.sv
// Bench for eg_slot_sched: directed plan steps plus a random phase, checked
// against a slot/frame-level reference model.
module tb_eg_slot_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic [6:0] lfo_in = '0;
   logic [4:0] slot_out;
   logic       frame_start, op_valid, amsen, ssg_inv;
   logic [6:0] tl, lfo_mod;
   logic [1:0] ams;

   eg_slot_sched_if wif();

   eg_slot_sched dut (
      .clk(clk), .rst(rst), .cen(cen), .wr(wif), .lfo_mod_in(lfo_in),
      .slot_out(slot_out), .frame_start(frame_start), .op_valid(op_valid),
      .tl(tl), .amsen(amsen), .ams(ams), .ssg_inv(ssg_inv), .lfo_mod(lfo_mod)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model: register file contents and the frame position
   int m_tl [24];
   int m_amsen [24];
   int m_ssg [24];
   int m_ams [6];
   int m_cnt;
   int e_slot, e_fs, e_ov, e_tl, e_amsen, e_ams, e_ssg, e_lfo, e_err;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 24; i++) begin m_tl[i] = 0; m_amsen[i] = 0; m_ssg[i] = 0; end
      for (int i = 0; i < 6; i++) m_ams[i] = 0;
      m_cnt = 0;
      e_slot = 0; e_fs = 0; e_ov = 0; e_tl = 0; e_amsen = 0;
      e_ams = 0; e_ssg = 0; e_lfo = 0; e_err = 0;
   endtask

   task automatic check_all(input string ph, input logic exp_ready);
      chk({ph, ".slot"},  8'(slot_out),    8'(e_slot));
      chk({ph, ".fs"},    8'(frame_start), 8'(e_fs));
      chk({ph, ".ov"},    8'(op_valid),    8'(e_ov));
      chk({ph, ".tl"},    8'(tl),          8'(e_tl));
      chk({ph, ".amsen"}, 8'(amsen),       8'(e_amsen));
      chk({ph, ".ams"},   8'(ams),         8'(e_ams));
      chk({ph, ".ssg"},   8'(ssg_inv),     8'(e_ssg));
      chk({ph, ".lfo"},   8'(lfo_mod),     8'(e_lfo));
      chk({ph, ".err"},   8'(wif.wr_err),  8'(e_err));
      chk({ph, ".rdy"},   8'(wif.wr_ready), 8'(exp_ready));
   endtask

   // one RUN clock: drive, predict from the model, check, then commit write
   task automatic tick(input string ph, input logic c, input logic wv,
                       input logic [4:0] a, input logic [1:0] s, input logic [6:0] d);
      @(negedge clk);
      cen = c; wif.wr_valid = wv; wif.wr_addr = a; wif.wr_sel = s; wif.wr_data = d;
      if (c) begin
         e_slot = m_cnt; e_fs = (m_cnt == 0); e_ov = 1;
         e_tl = m_tl[m_cnt]; e_amsen = m_amsen[m_cnt];
         e_ssg = m_ssg[m_cnt]; e_ams = m_ams[m_cnt % 6];
         if (m_cnt == 0) e_lfo = int'(lfo_in);
         m_cnt = (m_cnt + 1) % 24;
      end else e_ov = 0;
      e_err = 0;
      if (wv) begin
         if (a >= 24 || s == 3) e_err = 1;
         else if (s == 0) m_tl[a] = int'(d);
         else if (s == 1) begin m_amsen[a] = int'(d[2]); m_ams[a % 6] = int'(d[1:0]); end
         else m_ssg[a] = int'(d[0]);
      end
      @(posedge clk); #1;
      check_all(ph, 1'b1);
   endtask

   // reset with a write pending on the same edges, then time the INIT sweep
   task automatic do_reset(input int n);
      int lows;
      @(negedge clk);
      rst = 1; cen = 1;
      wif.wr_valid = 1; wif.wr_addr = 5'd3; wif.wr_sel = 2'd0; wif.wr_data = 7'h44;
      model_clear();
      repeat (n) begin
         @(posedge clk); #1;
         check_all("rst", 1'b0);
      end
      @(negedge clk);
      rst = 0; cen = 0; wif.wr_valid = 0;
      lows = 0;
      while (wif.wr_ready !== 1'b1 && lows < 100) begin
         lows++;
         @(negedge clk);
      end
      chk("init_len", 8'(lows), 8'd24);
      check_all("post_init", 1'b1);
   endtask

   initial begin
      wif.wr_valid = 0; wif.wr_addr = '0; wif.wr_sel = '0; wif.wr_data = '0;

      // reset and first slot
      do_reset(3);
      tick("first", 1, 0, 0, 0, 0);

      // round robin: 50 cen clocks total
      repeat (49) tick("rr", 1, 0, 0, 0, 0);

      // field writes while stalled, then a full frame plus margin
      tick("wr_tl",  0, 1, 5'd5,  2'd0, 7'h55);
      tick("wr_ams", 0, 1, 5'd11, 2'd1, 7'b111);
      tick("wr_ssg", 0, 1, 5'd17, 2'd2, 7'h01);
      repeat (26) tick("fields", 1, 0, 0, 0, 0);

      // collision: tl[7] written on the edge that issues slot 7
      for (int g = 0; g < 24 && m_cnt != 7; g++) tick("to7", 1, 0, 0, 0, 0);
      tick("coll", 1, 1, 5'd7, 2'd0, 7'h12);
      chk("coll_old", 8'(tl), 8'h00);
      repeat (24) tick("coll_nf", 1, 0, 0, 0, 0);

      // invalid writes: out-of-range address and reserved select
      tick("bad_addr", 1, 1, 5'd30, 2'd0, 7'h3C);
      chk("bad_addr_err", 8'(wif.wr_err), 8'd1);
      tick("bad_sel",  1, 1, 5'd2,  2'd3, 7'h3C);
      chk("bad_sel_err", 8'(wif.wr_err), 8'd1);
      repeat (24) tick("bad_nf", 1, 0, 0, 0, 0);

      // LFO latch: change at slot 4, must only appear from next slot 0
      lfo_in = 7'h10;
      for (int g = 0; g < 25 && m_cnt != 1; g++) tick("to0", 1, 0, 0, 0, 0);
      chk("lfo_10", 8'(lfo_mod), 8'h10);
      for (int g = 0; g < 24 && m_cnt != 5; g++) tick("to4", 1, 0, 0, 0, 0);
      lfo_in = 7'h7F;
      tick("lfo_chg", 1, 0, 0, 0, 0);
      chk("lfo_hold", 8'(lfo_mod), 8'h10);
      for (int g = 0; g < 25 && m_cnt != 1; g++) tick("lfo_wrap", 1, 0, 0, 0, 0);
      chk("lfo_7f", 8'(lfo_mod), 8'h7F);

      // stall 5 clocks
      repeat (5) tick("stall", 0, 0, 0, 0, 0);
      repeat (3) tick("unstall", 1, 0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) lfo_in = 7'($urandom);
         tick("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 31)), 2'($urandom), 7'($urandom));
      end

      // mid-frame reset at slot 13 with a write pending, storage must be clean
      for (int g = 0; g < 25 && m_cnt != 14; g++) tick("to13", 1, 0, 0, 0, 0);
      do_reset(1);
      repeat (26) tick("after_rst", 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eg_slot_sched.md
# eg_slot_sched

Slot scheduler and operand register file for the envelope-level limiter. It time-multiplexes one limiter datapath across 24 operator slots (6 channels × 4 operators). On each clock-enable it steps a slot counter and presents that slot's total level, AM enable/sensitivity, SSG-inversion flag and a frame-stable LFO sample. It sits between the CPU register-write path and the limiter; the envelope generator supplies the limiter's pure EG input separately, aligned to `slot_out`.

## Interface
Parameters:
- `NUM_SLOTS`, 24: slots per frame; the counter wraps at `NUM_SLOTS-1`.
- `NUM_CH`, 6: channels; channel = slot % `NUM_CH`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cen`  in  1  clock enable; slot advance qualifier.
- `wr_valid`  in  1  register-write request.
- `wr_ready`  out  1  write accepted when high together with `wr_valid`.
- `wr_addr`  in  5  target slot, 0..23.
- `wr_sel`  in  2  field select: 0 = tl, 1 = {amsen, ams}, 2 = ssg_inv, 3 = reserved.
- `wr_data`  in  7  write data; LSB-aligned for narrower fields.
- `wr_err`  out  1  one-clock pulse when an accepted write has `wr_addr >= 24` or `wr_sel == 3`.
- `lfo_mod_in`  in  7  live LFO modulation value.
- `slot_out`  out  5  slot whose operands are on the outputs.
- `frame_start`  out  1  high while `slot_out == 0` is presented.
- `op_valid`  out  1  one-clock pulse after each operand update.
- `tl`  out  7  total level of `slot_out`.
- `amsen`  out  1  AM enable of `slot_out`.
- `ams`  out  2  AM sensitivity of the channel of `slot_out`.
- `ssg_inv`  out  1  SSG inversion flag of `slot_out`.
- `lfo_mod`  out  7  LFO sample, frame-latched.

## Operation
- **States.** INIT and RUN.
- **Reset.** `rst` forces INIT from any state, including mid-frame or mid-write:
  - init index and slot counter cleared to 0;
  - all outputs 0, including `wr_ready`, `op_valid`, `frame_start`, `wr_err`.
- **INIT.**
  - One entry per clock, independent of `cen`, clears tl[i]=0, amsen[i]=0, ssg_inv[i]=0, and ams[i%6]=0 for i = 0..23.
  - Takes 24 clocks, then moves to RUN.
  - `wr_ready` stays 0 throughout.
- **RUN.**
  - `wr_ready` = 1 every clock.
  - On each clock with `cen`=1, register: `slot_out` ← cnt, operands ← regfile[cnt], `op_valid` ← 1, `frame_start` ← (cnt==0). Then cnt ← (cnt==23) ? 0 : cnt+1.
  - On a clock with `cen`=0, `op_valid` ← 0 and all other outputs hold.
- **LFO latch.** `lfo_mod` ← `lfo_mod_in` only on the `cen` edge that issues slot 0; it is constant for the other 23 slots.
- **Write fields.**
  - sel 0: tl[addr] ← data[6:0].
  - sel 1: amsen[addr] ← data[2], ams[addr%6] ← data[1:0].
  - sel 2: ssg_inv[addr] ← data[0].
- **Invalid writes.** Address ≥ 24 or sel 3: the handshake completes, nothing is stored, and `wr_err` pulses.
- **Write/read collision.** Read-before-write. A slot issued on the same edge a write to it lands gets the old value; the new value appears next frame. An ams write to a channel takes effect for every later slot of that channel.
- **Address mapping.** Slot modulo 6 uses a 0..23 lookup or a subtract-compare, not a divider.

## Timing
- Write-to-storage latency: 1 clock after the accepting edge.
- Operand latency: 1 clock after the `cen` edge that selects the slot.
- A frame is exactly 24 `cen` pulses.
- First RUN `cen` always issues slot 0 with `frame_start`=1.
- `cen` held high gives one slot per clock; `cen`=0 for N clocks stalls N clocks with no slot skipped.
- `rst` asserted on the same edge as `cen` or a write: reset wins, and the write is dropped.

## Structure
- **Shared package:**
  - `NUM_SLOTS`, `NUM_CH`;
  - `wr_sel` encodings (`SEL_TL`, `SEL_AMS`, `SEL_SSG`);
  - state enum {INIT, RUN};
  - slot-to-channel lookup function.
- **Sub-module `eg_slot_regs`:** 24×(7+1+1) slot storage plus 6×2 channel storage.
  - One synchronous write port.
  - One read port; combinational read of the old value.
  - Clear port driven by INIT.
- **Top level:** FSM, slot counter, LFO latch, output registers, handshake.

## Test plan
- **Reset/init:** assert `rst` 3 clocks, release.
  - `wr_ready`=0 for exactly 24 clocks, then 1.
  - First `cen` gives `slot_out`=0, `frame_start`=1, all operands 0.
- **Round-robin wrap:** `cen` held high for 50 clocks.
  - `slot_out` sequence 0..23,0..23,0,1.
  - `frame_start` high only at slot 0.
  - `op_valid` high every clock.
- **Field writes:** write tl[5]=0x55, sel1 to slot 11 with data=0b111, ssg_inv[17]=1.
  - Next frame: slot 5 tl=0x55.
  - Slots 5, 11, 17 and 23 show ams=3 (channel 5).
  - Only slot 11 shows amsen=1; slot 17 ssg_inv=1.
- **Collision and invalid writes:**
  - Write tl[7]=0x12 on the edge issuing slot 7: outputs old 0, next frame 0x12.
  - Write addr 30 and, separately, sel 3: `wr_err` pulses, no slot changes.
- **LFO latch and stall:**
  - Change `lfo_mod_in` from 0x10 to 0x7F at slot 4: `lfo_mod` stays 0x10 until slot 0, then 0x7F.
  - `cen`=0 for 5 clocks: outputs frozen, `op_valid`=0.
- **Mid-frame reset:** `rst` at slot 13 with a pending write.
  - Write is dropped.
  - INIT is rerun and all storage reads 0.
  - Frame restarts at slot 0.
